// File: rtl/bcd_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_adder_ctrl
// Brief    : Digit-serial packed-BCD adder controller (one digit per clock,
//            LSD first). Optional macro BCD_SERIAL_INVALID_CHECK_EN enables
//            the sticky non-BCD digit flag on Invalid.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_serial_adder_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [4*DIGITS-1:0]   A,
  input  logic [4*DIGITS-1:0]   B,
  input  logic                  Carry_In,
  output logic [4*DIGITS-1:0]   S,
  output logic                  Carry_Out,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;

  logic [4:0]      dig_z;
  logic            dig_cout;
  logic [3:0]      dig_sum;
  logic [W-1:0]    acc_next;

  // Single-digit decimal adder; applies +6 correction even to non-BCD digits.
  always_comb begin
    dig_z    = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'd0, carry_q};
    dig_cout = dig_z[4] | (dig_z[3] & dig_z[2]) | (dig_z[3] & dig_z[1]);
    dig_sum  = dig_z[3:0] + (dig_cout ? 4'd6 : 4'd0);
  end

  // Result digits enter from the top; the final digit goes straight to S.
  generate
    if (DIGITS == 1) begin : g_acc_single
      assign acc_next = dig_sum;
    end else begin : g_acc_multi
      logic [W-5:0] acc_q;
      assign acc_next = {dig_sum, acc_q};
      always_ff @(posedge Clk) begin
        if (Reset) begin
          acc_q <= '0;
        end else if (state_q == RUN) begin
          acc_q <= acc_next[W-1:4];
        end
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Carry_In;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) begin
          s_d     = acc_next;
          cout_d  = dig_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

`ifdef BCD_SERIAL_INVALID_CHECK_EN
  logic inv_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      inv_q <= 1'b0;
    end else if (state_q == IDLE && Start) begin
      inv_q <= 1'b0;
    end else if (state_q == RUN && (a_q[3:0] > 4'd9 || b_q[3:0] > 4'd9)) begin
      inv_q <= 1'b1;
    end
  end
  assign Invalid = inv_q;
`else
  assign Invalid = 1'b0;
`endif

  assign S         = s_q;
  assign Carry_Out = cout_q;
  assign Busy      = (state_q == RUN);
  assign Done      = (state_q == DONE);

endmodule
`default_nettype wire

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Digit-serial controller that adds two multi-digit packed-BCD operands using one shared single-digit BCD adder. It latches both operands on a start request, then feeds the single-digit adder one digit pair per clock, least-significant digit first. It chains the decimal carry through a carry flip-flop and presents the full result with a one-cycle Done pulse. It sits above the single-digit BCD adder and is the multi-digit front end for decimal datapaths.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); operand width is 4*DIGITS bits.
- Clk  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  4*DIGITS  packed-BCD operand A; digit i is A[4i+3:4i], i=0 is least significant.
- B  input  4*DIGITS  packed-BCD operand B, same packing.
- Carry_In  input  1  decimal carry into digit 0.
- S  output  4*DIGITS  registered packed-BCD sum.
- Carry_Out  output  1  registered decimal carry out of the top digit.
- Busy  output  1  high in RUN.
- Done  output  1  one-cycle pulse when S/Carry_Out become valid.
- Invalid  output  1  sticky per-operation flag for a non-BCD digit (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
- IDLE, Start=1:
  - Copy A and B into internal shift registers.
  - Carry flip-flop <= Carry_In; digit counter <= 0; Invalid <= 0.
  - Go to RUN.
- IDLE, Start=0: hold.
- RUN, each cycle:
  - Present the low digit of each shift register plus the carry flip-flop to the single-digit adder.
  - Shift the result digit into an accumulator from the top.
  - Shift both operand registers right by 4.
  - Carry flip-flop <= digit carry; counter increments.
- RUN exit: after DIGITS RUN cycles, copy the accumulator to S and the final carry to Carry_Out, then go to DONE.
- DONE: Done=1 for exactly one cycle, then IDLE unconditionally.
- Start is ignored in RUN and DONE. It is not queued, and operands presented then are not captured.
- Digit arithmetic for digits a, b and carry c:
  - z = a+b+c (5-bit).
  - cout = z[4] | (z[3]&z[2]) | (z[3]&z[1]).
  - digit = (z[3:0] + 6*cout) mod 16.
  - The same rule applies to non-BCD digits; no saturation.
- S and Carry_Out hold their last result through IDLE and during the next RUN. They change only on the RUN→DONE edge.
- Reset, in any state including mid-RUN:
  - State goes to IDLE; shift registers, accumulator, counter and carry clear.
  - S, Carry_Out, Busy, Done and Invalid all go to 0.
  - The aborted operation produces no Done.

## Timing
- Edge E0 samples Start=1 in IDLE → Busy=1 after E0.
- RUN occupies edges E1..E_DIGITS; S/Carry_Out update at E_DIGITS.
- Done=1 and Busy=0 after E_DIGITS; Done=0 after E_DIGITS+1.
- Start→Done latency is DIGITS+1 edges. Throughput is one operation per DIGITS+2 cycles (the earliest next Start is sampled at E_DIGITS+2).
- Busy and Done are never high together.
- DIGITS=1 is legal: one RUN cycle.
- The counter is ceil(log2(DIGITS+1)) bits wide and does not wrap within an operation.

## Configuration
- Macro BCD_SERIAL_INVALID_CHECK_EN.
- Defined:
  - During RUN, if either digit presented to the adder is >9, Invalid is set.
  - Invalid stays set until the next accepted Start or Reset.
  - It is valid alongside Done, and the sum is still produced by the rule above.
- Undefined:
  - Invalid is tied to 0 and the check logic is absent.
  - The port remains so the interface is unchanged.

## Test plan
DIGITS=4 unless stated.
- A=0x1234, B=0x5678, Carry_In=0, Start → Done 5 edges later; S=0x6912, Carry_Out=0; Busy high exactly 4 cycles.
- A=0x9999, B=0x0001, Carry_In=0 → S=0x0000, Carry_Out=1; then A=0x0000, B=0x0000, Carry_In=1 → S=0x0001, Carry_Out=0.
- Start held high continuously with A=0x0005, B=0x0005 → operations complete every 6 cycles, each S=0x0010. Changing A during RUN does not affect the in-flight result.
- Start, then Reset at the 2nd RUN cycle → next cycle all outputs 0, no Done. A fresh Start with 0x4321+0x1111 gives S=0x5432.
- With the macro: A=0x00A0, B=0x0000 → Invalid=1 at Done and S=0x0100 (rule applied: A+6 wraps, carry 1). The next Start with valid operands clears Invalid. Without the macro, Invalid stays 0.
- DIGITS=1: A=0x7, B=0x8, Carry_In=1 → Done 2 edges after Start; S=0x6, Carry_Out=1.
